// File: rtl/simon_pkg.sv
// ============================================================================
// Module      : simon_pkg
// Description : Shared definitions for the PS/2 keyboard receiver and the
//               game datapath: scan-code prefix bytes, receiver state
//               encoding, the key codes the datapath reacts to, and a parity
//               helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package simon_pkg;

  // Scan-code prefix bytes folded into a single key event
  localparam logic [7:0] PS2_BREAK = 8'hF0;
  localparam logic [7:0] PS2_EXT   = 8'hE0;

  // Key codes consumed by the game datapath
  localparam logic [7:0] KEY_GREEN  = 8'h1D;
  localparam logic [7:0] KEY_RED    = 8'h1C;
  localparam logic [7:0] KEY_YELLOW = 8'h1B;
  localparam logic [7:0] KEY_BLUE   = 8'h23;
  localparam logic [7:0] KEY_ENTER  = 8'h5A;

  // Device-to-host frame receiver states
  typedef enum logic [1:0] {
    RX_IDLE   = 2'd0,
    RX_DATA   = 2'd1,
    RX_PARITY = 2'd2,
    RX_STOP   = 2'd3
  } ps2_rx_state_e;

  // Odd parity holds when the data bits and the parity bit XOR to one.
  function automatic logic ps2_odd_parity_ok(input logic [7:0] data,
                                             input logic       par);
    return (^data) ^ par;
  endfunction

endpackage : simon_pkg

`default_nettype wire

// File: rtl/ps2_sync_filter.sv
// ============================================================================
// Module      : ps2_sync_filter
// Description : Conditions the raw PS/2 pins. Both pins pass through a
//               2-flop synchronizer; the clock line is then glitch filtered
//               and its falling edges are reported as a one-cycle pulse.
// Revision    : 1.0 - initial release
//
// Parameters  :
//   FILTER_LEN : consecutive differing samples needed to move the filtered
//                clock to a new level (2..16)
// Ports       :
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   ps2_clk  in  raw PS/2 clock pin
//   ps2_data in  raw PS/2 data pin
//   fall     out one-cycle pulse on a falling edge of the filtered clock
//   data_s   out synchronized PS/2 data
// ============================================================================
`default_nettype none

module ps2_sync_filter #(
  parameter int FILTER_LEN = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic fall,
  output logic data_s
);

  localparam int CNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  logic [1:0]       clk_sync;
  logic [1:0]       data_sync;
  logic             clk_filt;
  logic [CNT_W-1:0] filt_cnt;
  logic             clk_s;

  assign clk_s  = clk_sync[1];
  assign data_s = data_sync[1];

  // Synchronizers reset high to match an idle, pulled-up bus
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  // The counter tracks how many samples in a row disagree with the filtered
  // level; any agreeing sample restarts the run, so short glitches vanish.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      filt_cnt <= '0;
      fall     <= 1'b0;
    end else begin
      fall <= 1'b0;
      if (clk_s == clk_filt) begin
        filt_cnt <= '0;
      end else if (filt_cnt == CNT_LAST) begin
        clk_filt <= clk_s;
        filt_cnt <= '0;
        // New level is the complement of the old one, so an old high is a fall
        fall     <= clk_filt;
      end else begin
        filt_cnt <= filt_cnt + 1'b1;
      end
    end
  end

endmodule : ps2_sync_filter

`default_nettype wire

// File: rtl/ps2_keyboard_rx.sv
// ============================================================================
// Module      : ps2_keyboard_rx
// Description : PS/2 keyboard receiver. Deframes 11-bit device-to-host
//               frames, folds F0 (break) and E0 (extended) prefixes into a
//               single key event, and flags parity/stop/timeout errors.
// Revision    : 1.0 - initial release
//
// Build option:
//   PS2_PARITY_CHECK_EN : when defined, frames with bad odd parity raise
//                         frame_err and are discarded; when undefined the
//                         parity bit is captured but ignored.
//
// Parameters  :
//   FILTER_LEN     : PS/2 clock glitch filter length (2..16)
//   TIMEOUT_CYCLES : max clk cycles between falling ps2_clk edges in a frame
// Ports       :
//   clk           in  system clock
//   rst_n         in  asynchronous active-low reset
//   ps2_clk       in  raw PS/2 clock pin
//   ps2_data      in  raw PS/2 data pin
//   keycode       out last decoded scan code, prefixes stripped
//   make          out 1 = press, 0 = release
//   extended      out 1 when keycode was preceded by E0
//   keycode_ready out one-cycle strobe, outputs above updated with it
//   frame_err     out one-cycle strobe on parity, stop or timeout error
// ============================================================================
`default_nettype none

module ps2_keyboard_rx
  import simon_pkg::*;
#(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] keycode,
  output logic       make,
  output logic       extended,
  output logic       keycode_ready,
  output logic       frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic            fall;
  logic            data_s;
  ps2_rx_state_e   state;
  logic [2:0]      bit_cnt;
  logic [7:0]      shift;
  logic            par_bit;
  logic [TO_W-1:0] to_cnt;
  logic            brk_flag;
  logic            ext_flag;
  logic            parity_ok;

  ps2_sync_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_sync_filter (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_data (ps2_data),
    .fall     (fall),
    .data_s   (data_s)
  );

`ifdef PS2_PARITY_CHECK_EN
  assign parity_ok = ps2_odd_parity_ok(shift, par_bit);
`else
  // Parity is still captured so the frame timing is identical in both builds
  logic parity_unused;
  assign parity_unused = ps2_odd_parity_ok(shift, par_bit);
  assign parity_ok     = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= RX_IDLE;
      bit_cnt       <= '0;
      shift         <= '0;
      par_bit       <= 1'b0;
      to_cnt        <= '0;
      brk_flag      <= 1'b0;
      ext_flag      <= 1'b0;
      keycode       <= 8'h00;
      make          <= 1'b0;
      extended      <= 1'b0;
      keycode_ready <= 1'b0;
      frame_err     <= 1'b0;
    end else begin
      keycode_ready <= 1'b0;
      frame_err     <= 1'b0;

      // Inter-edge watchdog: restarted by every edge, idle outside a frame
      if (fall) begin
        to_cnt <= '0;
      end else if (state != RX_IDLE) begin
        to_cnt <= to_cnt + 1'b1;
      end

      // An edge arriving on the expiry cycle wins over the timeout
      if (fall) begin
        unique case (state)
          RX_IDLE: begin
            if (!data_s) begin
              state   <= RX_DATA;
              bit_cnt <= '0;
            end
          end
          RX_DATA: begin
            shift   <= {data_s, shift[7:1]};
            bit_cnt <= bit_cnt + 1'b1;
            if (bit_cnt == 3'd7) begin
              state <= RX_PARITY;
            end
          end
          RX_PARITY: begin
            par_bit <= data_s;
            state   <= RX_STOP;
          end
          RX_STOP: begin
            state <= RX_IDLE;
            if (data_s && parity_ok) begin
              if (shift == PS2_EXT) begin
                ext_flag <= 1'b1;
              end else if (shift == PS2_BREAK) begin
                brk_flag <= 1'b1;
              end else begin
                keycode       <= shift;
                make          <= ~brk_flag;
                extended      <= ext_flag;
                keycode_ready <= 1'b1;
                brk_flag      <= 1'b0;
                ext_flag      <= 1'b0;
              end
            end else begin
              // A corrupted byte may have been part of a prefixed sequence
              frame_err <= 1'b1;
              brk_flag  <= 1'b0;
              ext_flag  <= 1'b0;
            end
          end
          default: state <= RX_IDLE;
        endcase
      end else if ((state != RX_IDLE) && (to_cnt == TO_LAST)) begin
        frame_err <= 1'b1;
        state     <= RX_IDLE;
        to_cnt    <= '0;
        brk_flag  <= 1'b0;
        ext_flag  <= 1'b0;
      end
    end
  end

endmodule : ps2_keyboard_rx

`default_nettype wire

// File: doc/ps2_keyboard_rx.md
# ps2_keyboard_rx

Receives the PS/2 keyboard serial stream and produces the `keycode` / `make` / `keycode_ready` triple that the game datapath consumes. It sits between the board's PS/2 pins and the datapath. It synchronizes and filters the open-collector `ps2_clk` / `ps2_data` lines, deframes 11-bit device-to-host frames, and folds `F0` (break) and `E0` (extended) prefix bytes into one decoded key event per scan-code sequence.

## Interface
- `FILTER_LEN`, default 4: number of consecutive equal synchronized samples needed before the filtered `ps2_clk` changes (range 2..16).
- `TIMEOUT_CYCLES`, default 50000: maximum `clk` cycles between falling `ps2_clk` edges inside a frame (1 ms at 50 MHz).

Ports:
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `ps2_clk` input 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_data` input 1: raw PS/2 data pin, asynchronous to `clk`.
- `keycode` output 8: last decoded scan code, with prefixes stripped.
- `make` output 1: 1 = key press, 0 = key release, for `keycode`.
- `extended` output 1: 1 when `keycode` was preceded by `E0`.
- `keycode_ready` output 1: single-cycle strobe; `keycode` / `make` / `extended` are updated in the same cycle.
- `frame_err` output 1: single-cycle strobe on a parity, stop-bit or timeout error.

## Operation
- Input conditioning:
  - Both pins pass through a 2-flop synchronizer.
  - `ps2_clk` is then filtered: the filtered value takes the new level after `FILTER_LEN` identical samples.
  - A falling edge of the filtered clock samples synchronized `ps2_data`.
- Frame format: start(0), D0..D7 LSB first, odd parity, stop(1).
- States:
  - IDLE:
    - On falling edge with data=0, go to DATA and clear bit count.
    - On falling edge with data=1, ignore the edge and stay in IDLE.
  - DATA: shift in 8 bits; after the 8th, go to PARITY.
  - PARITY: capture the bit and go to STOP.
  - STOP: on falling edge, validate the frame and return to IDLE.
- Frame validation:
  - Valid frame: XOR of D0..D7 and parity = 1, and stop = 1.
  - Invalid frame: pulse `frame_err`, discard the byte, clear the break and ext flags.
- Byte decode (valid frames only):
  - `E0`: set ext flag; no strobe.
  - `F0`: set break flag; no strobe.
  - Any other byte:
    - `keycode` ← byte.
    - `make` ← ~break.
    - `extended` ← ext.
    - Pulse `keycode_ready`, then clear both flags.
- Timeout:
  - A counter runs while the state ≠ IDLE and resets on every falling edge.
  - On reaching `TIMEOUT_CYCLES`: pulse `frame_err`, go to IDLE, clear both flags.
- Output hold: `keycode`, `make` and `extended` hold their values until the next strobe.
- Bytes `E1`, `AA` and `FA` are not special: they are emitted as ordinary keycodes.

## Timing
- Reset values:
  - `keycode` = 8'h00, `make` = 0, `extended` = 0, `keycode_ready` = 0, `frame_err` = 0.
  - State = IDLE, flags = 0, synchronizer and filter flops = 1 (idle-high bus).
- Latency:
  - `keycode_ready` is asserted exactly `FILTER_LEN`+3 `clk` cycles after the `ps2_clk` pin falls for the stop bit.
  - Same latency applies to `frame_err` on a stop-bit or parity error.
- Strobe width: `keycode_ready` and `frame_err` are high for exactly one cycle and are never high together.
- Reset mid-frame: all state is discarded immediately. The partial frame produces no strobe, and the next complete frame decodes normally.
- Simultaneous events: a falling edge in the same cycle the timeout expires counts as an edge; no timeout occurs.
- Minimum `clk`: 16× `FILTER_LEN` × the PS/2 clock rate (about 16.7 kHz max).

## Configuration
- `PS2_PARITY_CHECK_EN` defined: parity is checked as described above.
- Undefined:
  - The parity bit is captured but ignored.
  - Only stop-bit errors and timeouts raise `frame_err`.
  - A bad-parity frame is decoded as valid.

## Structure
- Shared package `simon_pkg` holds:
  - `PS2_BREAK` = 8'hF0 and `PS2_EXT` = 8'hE0.
  - The receiver state enum (IDLE, DATA, PARITY, STOP).
  - Key constants used by the datapath: green = 8'h1D, red = 8'h1C, yellow = 8'h1B, blue = 8'h23, enter = 8'h5A.
- One sub-module, `ps2_sync_filter`:
  - Contains the 2-flop synchronizer, the `FILTER_LEN` filter and falling-edge detection.
  - Outputs `fall` (1-cycle pulse) and `data_s`.
- The frame FSM, prefix decode and timeout counter live in the top module.

## Test plan
- Frame `1D` (odd parity = 1) at 12.5 kHz → one `keycode_ready`; `keycode`=8'h1D, `make`=1, `extended`=0; strobe occurs exactly `FILTER_LEN`+3 cycles after the stop-bit pin fall.
- Frames `F0`, `1D` → no strobe after `F0`; after `1D`: `keycode`=8'h1D, `make`=0, one strobe.
- Frames `E0`, `F0`, `75` → one strobe; `keycode`=8'h75, `make`=0, `extended`=1; next frame `5A` → `make`=1, `extended`=0.
- Frame `1C` with wrong parity:
  - With the macro defined → `frame_err` pulse, no `keycode_ready`, outputs unchanged.
  - Without the macro → decoded as 8'h1C.
- 4 bits of a frame, then bus idle for `TIMEOUT_CYCLES` → one `frame_err`; the following good `23` frame → `keycode`=8'h23.
- Assert `rst_n` after 6 bits of `F0`, release, send `1B` → `keycode`=8'h1B, `make`=1; no strobe during reset.
